inst_fetch_responder: RTL and testbench
=======================================

# inst_fetch_responder

Instruction-side responder of the memory controller: the other end of the fetch handshake driven by the instruction fetcher. It latches a fetch request, performs four little-endian byte reads on the byte-wide RAM bus, and assembles a 32-bit instruction. It then returns the instruction with a one-cycle completion pulse. It also honours the fetcher's drop signal, which is raised on ROB-commit redirects. It sits inside the memory controller, between the fetcher and the shared RAM port, and takes a grant from the controller's bus arbiter before starting.

## Interface
- No parameters. Widths come from `ADDR_TYPE` (32), `INS_TYPE` (32) and `BYTE_TYPE` (8) in the shared defines.
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rdy  in  1  global ready; low pauses the block.
- ena_from_if  in  1  fetch request, sampled at a clock edge.
- pc_from_if  in  32  byte address of the instruction to fetch, valid when ena_from_if is high.
- drop_flag_from_if  in  1  abort any accepted or in-flight fetch.
- ok_flag_to_if  out  1  one-cycle pulse: inst_to_if is valid.
- inst_to_if  out  32  assembled instruction; held until the next ok pulse.
- bus_grant  in  1  arbiter permission to start using the RAM bus.
- if_busy  out  1  high while a request is latched or in flight (WAIT_GRANT or READ); used by the arbiter.
- mem_din  in  8  RAM read data.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  RAM write enable; always 0 from this block.

## Operation
- States: IDLE, WAIT_GRANT, READ. Internal registers:
  - req_pc (32)
  - issue_idx (0..4): bytes addressed so far
  - recv_idx (0..4): bytes captured so far
  - byte buffer (4×8)
- Reset (async): state=IDLE, ok_flag_to_if=0, inst_to_if=0, mem_a=0, mem_wr=0, if_busy=0, both indices 0, req_pc=0.
- rdy=0: no state changes, except that a READ in progress restarts. The state stays READ, both indices clear to 0, and mem_a←req_pc once rdy returns. ok_flag_to_if is forced to 0 while rdy is low.
- Priority at each edge (rdy=1): drop, then the current state action.
- Drop: state←IDLE, indices←0, ok_flag_to_if←0 (a pulse due at this edge is suppressed), mem_a unchanged, inst_to_if unchanged. An ena_from_if arriving at the same edge is ignored.
- IDLE:
  - ena_from_if=1: req_pc←pc_from_if.
  - If bus_grant=1, enter READ with mem_a←pc_from_if, issue_idx←1, recv_idx←0.
  - Otherwise enter WAIT_GRANT.
- WAIT_GRANT: on bus_grant=1, enter READ with mem_a←req_pc, issue_idx←1. ena_from_if is ignored.
- READ, each edge:
  - If issue_idx<4: mem_a←req_pc+issue_idx, issue_idx++.
  - If issue_idx≥2 (RAM data for byte recv_idx is on mem_din): byte[recv_idx]←mem_din, recv_idx++.
  - On capturing byte 3: inst_to_if←{mem_din, byte2, byte1, byte0}, ok_flag_to_if←1, state←IDLE.
- The arbiter does not revoke the grant during READ. ena_from_if is ignored while not in IDLE.
- ok_flag_to_if is cleared at every edge where it is not being set, so it is always a one-cycle pulse.
- Address arithmetic is 32-bit modulo; req_pc+3 wraps through 0xFFFFFFFF→0.

## Timing
- RAM latency: an address driven on mem_a during cycle k returns on mem_din during cycle k+1.
- Accept edge E0: mem_a=pc. E1: mem_a=pc+1. E2: capture byte0, mem_a=pc+2. E3: capture byte1, mem_a=pc+3. E4: capture byte2. E5: capture byte3, ok_flag_to_if=1.
- Latency: ok is high in the cycle following E5, i.e. 5 cycles after acceptance with the grant present. Each cycle spent in WAIT_GRANT adds one cycle.
- Earliest next accept: the edge after ok drops, because the fetcher re-raises ena one cycle after seeing ok.
- mem_a stays at the last issued address while idle; mem_wr is constant 0.

## Structure
- The shared defines file carries `ADDR_TYPE`, `INS_TYPE`, `BYTE_TYPE`, `TRUE`/`FALSE`, `ZERO_WORD`, `ZERO_ADDR`, and the state encodings for IDLE, WAIT_GRANT and READ.
- This is a single module. The byte assembly is a 4-entry register file, so no sub-module is warranted.
- The memory controller top instantiates this block next to the load/store responder and the arbiter.

## Test plan
- Basic fetch: RAM bytes 0x00..0x03 = 13 05 A0 00, request pc=0x0 with grant held high. Required: ok pulses once, 5 cycles after accept, with inst_to_if=0x00A00513. mem_a sequence is 0,1,2,3; mem_wr stays 0.
- Grant delay: request pc=0x100 with bus_grant low for 3 cycles. Required: if_busy high throughout, state WAIT_GRANT, mem_a unchanged. Ok follows 5 cycles after the grant edge, with the correct word.
- Drop mid-read: drop at E3 of a fetch at 0x40. Required: no ok pulse and inst_to_if keeps its old value. A new request at 0x80 then returns the 0x80 word.
- Drop coincident with completion (E5) and with a new ena: ok stays 0, state ends IDLE, and the ena is not accepted.
- rdy low for 2 cycles at E2: the read restarts from req_pc after rdy returns. Ok carries the correct word 5 cycles after the resume edge.
- Wrap and async reset: a fetch at 0xFFFFFFFE issues mem_a FFFFFFFE, FFFFFFFF, 0, 1. An rst pulse between edges mid-READ immediately zeroes all outputs and returns the block to IDLE.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// Shared definitions for the instruction-side fetch responder.
// Widths of addresses, instruction words and RAM bytes, boolean constants,
// zero constants and the responder state encoding.
package inst_fetch_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int INS_W  = 32;
  localparam int BYTE_W = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [INS_W-1:0]  ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  // Index value meaning "all four bytes addressed".
  localparam logic [2:0] IDX_FULL = 3'd4;
  // Index of the last byte of a word; it goes straight from mem_din into the word.
  localparam logic [2:0] IDX_LAST = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_READ       = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//   Latches a fetch request from the instruction fetcher, waits for the bus
//   arbiter's grant, performs four little-endian byte reads on the byte-wide
//   RAM bus and returns the assembled 32-bit instruction with a one-cycle
//   ok pulse. A drop from the fetcher abandons any accepted or in-flight fetch.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; low pauses the block (a READ restarts)
//   ena_from_if         fetch request
//   pc_from_if          byte address of the instruction to fetch
//   drop_flag_from_if   abort current fetch
//   ok_flag_to_if       one-cycle pulse, inst_to_if valid
//   inst_to_if          assembled instruction, held until the next ok
//   bus_grant           arbiter permission to start using the RAM bus
//   if_busy             high in WAIT_GRANT and READ
//   mem_din             RAM read data (one cycle after the address)
//   mem_a               RAM byte address
//   mem_wr              RAM write enable, always 0
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ena_from_if,
  input  logic [ADDR_W-1:0] pc_from_if,
  input  logic              drop_flag_from_if,
  output logic              ok_flag_to_if,
  output logic [INS_W-1:0]  inst_to_if,
  input  logic              bus_grant,
  output logic              if_busy,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [2:0]        issue_idx_q, issue_idx_d;
  logic [2:0]        recv_idx_q, recv_idx_d;
  logic              ok_q, ok_d;
  logic [INS_W-1:0]  inst_q, inst_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  // Bytes 0..2 only: byte 3 is taken directly from mem_din when the word completes.
  logic [2:0][BYTE_W-1:0] byte_buf_q, byte_buf_d;

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    issue_idx_d = issue_idx_q;
    recv_idx_d  = recv_idx_q;
    ok_d        = FALSE;
    inst_d      = inst_q;
    mem_a_d     = mem_a_q;
    byte_buf_d  = byte_buf_q;

    if (!rdy) begin
      // Bytes returned while paused cannot be trusted, so a READ starts over
      // from req_pc on the first edge with rdy back high.
      if (state_q == ST_READ) begin
        issue_idx_d = '0;
        recv_idx_d  = '0;
      end
    end else if (drop_flag_from_if) begin
      state_d     = ST_IDLE;
      issue_idx_d = '0;
      recv_idx_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena_from_if) begin
            req_pc_d = pc_from_if;
            if (bus_grant) begin
              state_d     = ST_READ;
              mem_a_d     = pc_from_if;
              issue_idx_d = 3'd1;
              recv_idx_d  = '0;
            end else begin
              state_d = ST_WAIT_GRANT;
            end
          end
        end

        ST_WAIT_GRANT: begin
          if (bus_grant) begin
            state_d     = ST_READ;
            mem_a_d     = req_pc_q;
            issue_idx_d = 3'd1;
            recv_idx_d  = '0;
          end
        end

        ST_READ: begin
          if (issue_idx_q < IDX_FULL) begin
            mem_a_d     = req_pc_q + ADDR_W'(issue_idx_q);
            issue_idx_d = issue_idx_q + 3'd1;
          end
          // Once two addresses have gone out, mem_din carries byte recv_idx.
          if (issue_idx_q >= 3'd2) begin
            if (recv_idx_q == IDX_LAST) begin
              inst_d      = {mem_din, byte_buf_q[2], byte_buf_q[1], byte_buf_q[0]};
              ok_d        = TRUE;
              state_d     = ST_IDLE;
              issue_idx_d = '0;
              recv_idx_d  = '0;
            end else begin
              byte_buf_d[recv_idx_q[1:0]] = mem_din;
              recv_idx_d                  = recv_idx_q + 3'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_pc_q    <= ZERO_ADDR;
      issue_idx_q <= '0;
      recv_idx_q  <= '0;
      ok_q        <= FALSE;
      inst_q      <= ZERO_WORD;
      mem_a_q     <= ZERO_ADDR;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      issue_idx_q <= issue_idx_d;
      recv_idx_q  <= recv_idx_d;
      ok_q        <= ok_d;
      inst_q      <= inst_d;
      mem_a_q     <= mem_a_d;
    end
  end

  // Assembly bytes are pure data; their content is only used after being refilled.
  always_ff @(posedge clk) begin
    byte_buf_q <= byte_buf_d;
  end

  assign ok_flag_to_if = ok_q;
  assign inst_to_if    = inst_q;
  assign mem_a         = mem_a_q;
  assign if_busy       = (state_q != ST_IDLE);
  assign mem_wr        = FALSE;

endmodule

// File: tb/tb_inst_fetch_responder.sv
`timescale 1ns/1ps
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst, rdy, ena_from_if, drop_flag_from_if, bus_grant;
  logic [31:0] pc_from_if;
  logic        ok_flag_to_if, if_busy, mem_wr;
  logic [31:0] inst_to_if, mem_a;
  logic [7:0]  mem_din;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] inst;
    int          due;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  logic [31:0] last_inst;
  logic [31:0] last_addr;

  inst_fetch_responder dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .ena_from_if       (ena_from_if),
    .pc_from_if        (pc_from_if),
    .drop_flag_from_if (drop_flag_from_if),
    .ok_flag_to_if     (ok_flag_to_if),
    .inst_to_if        (inst_to_if),
    .bus_grant         (bus_grant),
    .if_busy           (if_busy),
    .mem_din           (mem_din),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: a fixed instruction at 0..3, a hash of the address elsewhere.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'hA0;
      32'd3:   return 8'h00;
      default: begin
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[7:0];
      end
    endcase
  endfunction

  // Little-endian word at pc, addresses wrapping modulo 2^32.
  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    return {ram_byte(pc + 32'd3), ram_byte(pc + 32'd2), ram_byte(pc + 32'd1), ram_byte(pc)};
  endfunction

  // RAM with one cycle of read latency.
  always @(posedge clk) mem_din <= ram_byte(mem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ok pulse must match the oldest outstanding fetch, word and cycle.
  always @(negedge clk) begin
    if (ok_flag_to_if === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ok: inst %h at cycle %0d with no fetch outstanding", inst_to_if, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (inst_to_if !== mon_e.inst || cyc != mon_e.due) begin
          errors++;
          $display("FAIL ok_word: got %h at cycle %0d, expected %h at cycle %0d",
                   inst_to_if, cyc, mon_e.inst, mon_e.due);
        end
      end
      chk("mem_wr", 32'(mem_wr), 32'd0);
    end
  end

  // One fetch. gdelay: cycles spent in WAIT_GRANT. drop_d: drop at edge S+drop_d
  // (S = edge that starts READ), 0 = none; drop_ena raises ena at the drop edge.
  // p_at/p_len: rdy low for p_len edges starting at S+p_at (p_len 0 = none).
  task automatic fetch(input logic [31:0] pc, input int gdelay, input int drop_d,
                       input bit drop_ena, input int p_at, input int p_len);
    int          s_cyc;
    int          total;
    int          lastk;
    logic [31:0] exp;
    exp = ref_word(pc);
    @(negedge clk);
    ena_from_if = 1'b1;
    pc_from_if  = pc;
    bus_grant   = (gdelay == 0);
    @(negedge clk);
    ena_from_if = 1'b0;
    pc_from_if  = $urandom;
    for (int i = 0; i < gdelay; i++) begin
      chk("busy_wait", 32'(if_busy), 32'd1);
      chk("mem_a_wait", mem_a, last_addr);
      if (i == gdelay - 1) bus_grant = 1'b1;
      @(negedge clk);
    end
    s_cyc = cyc;
    total = 5 + ((p_len > 0) ? (p_at + p_len) : 0);
    if (drop_d == 0) sb.push_back('{inst: exp, due: s_cyc + total});
    for (int k = 0; k <= total; k++) begin
      if (p_len == 0 && k <= 3 && (drop_d == 0 || k < drop_d))
        chk("mem_a_seq", mem_a, pc + 32'(k));
      if (p_len > 0 && k == p_at + p_len) chk("mem_a_restart", mem_a, pc);
      if (p_len > 0 && k == p_at - 1) rdy = 1'b0;
      if (p_len > 0 && k == p_at + p_len - 1) rdy = 1'b1;
      if (drop_d > 0 && k == drop_d - 1) begin
        drop_flag_from_if = 1'b1;
        if (drop_ena) begin
          ena_from_if = 1'b1;
          pc_from_if  = $urandom;
        end
        @(negedge clk);
        drop_flag_from_if = 1'b0;
        ena_from_if       = 1'b0;
        lastk = (drop_d - 1 > 3) ? 3 : drop_d - 1;
        last_addr = pc + 32'(lastk);
        chk("busy_after_drop", 32'(if_busy), 32'd0);
        chk("inst_after_drop", inst_to_if, last_inst);
        chk("mem_a_after_drop", mem_a, last_addr);
        repeat (4) @(negedge clk);
        chk("busy_idle_after_drop", 32'(if_busy), 32'd0);
        return;
      end
      @(negedge clk);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("busy_done", 32'(if_busy), 32'd0);
    chk("inst_hold", inst_to_if, exp);
    last_inst = exp;
    last_addr = pc + 32'd3;
  endtask

  // Start a fetch and hit it with an asynchronous reset pulse between edges mid-READ.
  task automatic reset_mid_read(input logic [31:0] pc);
    @(negedge clk);
    ena_from_if = 1'b1;
    pc_from_if  = pc;
    bus_grant   = 1'b1;
    @(negedge clk);
    ena_from_if = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ok", 32'(ok_flag_to_if), 32'd0);
    chk("arst_inst", inst_to_if, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    chk("arst_busy", 32'(if_busy), 32'd0);
    chk("arst_mem_wr", 32'(mem_wr), 32'd0);
    #1 rst = 1'b0;
    last_inst = 32'd0;
    last_addr = 32'd0;
    repeat (6) @(negedge clk);
    chk("arst_idle", 32'(if_busy), 32'd0);
  endtask

  initial begin
    int g, sel, d, pa, pl;
    bit de;
    rst               = 1'b1;
    rdy               = 1'b1;
    ena_from_if       = 1'b0;
    drop_flag_from_if = 1'b0;
    bus_grant         = 1'b0;
    pc_from_if        = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ok", 32'(ok_flag_to_if), 32'd0);
    chk("rst_inst", inst_to_if, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_busy", 32'(if_busy), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    rst       = 1'b0;
    last_inst = 32'd0;
    last_addr = 32'd0;

    fetch(32'h0000_0000, 0, 0, 1'b0, 0, 0);   // basic fetch
    fetch(32'h0000_0100, 3, 0, 1'b0, 0, 0);   // grant delay
    fetch(32'h0000_0040, 0, 3, 1'b0, 0, 0);   // drop mid-read
    fetch(32'h0000_0080, 0, 0, 1'b0, 0, 0);
    fetch(32'h0000_0200, 0, 5, 1'b1, 0, 0);   // drop at completion with new ena
    fetch(32'h0000_0300, 0, 0, 1'b0, 2, 2);   // rdy low two cycles from E2
    fetch(32'hFFFF_FFFE, 0, 0, 1'b0, 0, 0);   // address wrap
    reset_mid_read(32'h0000_0500);
    fetch(32'h0000_0600, 1, 0, 1'b0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      g   = $urandom_range(0, 3);
      sel = $urandom_range(0, 3);
      d   = 0;
      de  = 1'b0;
      pa  = 0;
      pl  = 0;
      if (sel == 0) begin
        d  = $urandom_range(1, 5);
        de = 1'($urandom_range(0, 1));
      end else if (sel == 1) begin
        pa = $urandom_range(1, 4);
        pl = $urandom_range(1, 3);
      end
      fetch($urandom, g, d, de, pa, pl);
    end

    repeat (3) @(negedge clk);
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
